// File: rtl/cam_cfg_sequencer.sv
// Expands one camera configuration instruction into a stream of 3-byte sensor register
// writes over a valid/ready byte interface. It also keeps per-camera format state and raises trigger pulses.
module cam_cfg_sequencer #(
   parameter int NUM_CAMS = 2,
   parameter int CAM_W    = 1,
   parameter int TIMEOUT  = 4096
) (
   input  logic                  sysClk,
   input  logic                  rst_n,
   input  logic [7:0]            cmd_addr,
   input  logic [63:0]           cmd_data,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic [7:0]            i2c_byte,
   output logic                  i2c_valid,
   input  logic                  i2c_ready,
   output logic                  i2c_frame_last,
   output logic [CAM_W-1:0]      i2c_cam,
   output logic [2*NUM_CAMS-1:0] compression,
   output logic [NUM_CAMS-1:0]   rgb,
   output logic                  trigger,
   output logic [CAM_W-1:0]      trigger_cam,
   output logic [15:0]           trigger_index,
   output logic [9:0]            timestamp,
   output logic                  done,
   output logic                  error
);

   localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TO_EN = (TIMEOUT > 0);
   localparam logic [4:0] NUM_CAMS_L = 5'(NUM_CAMS);

   localparam logic [3:0] OP_TRIGGER = 4'd1;
   localparam logic [3:0] OP_TIMING  = 4'd2;
   localparam logic [3:0] OP_WINDOW  = 4'd3;
   localparam logic [3:0] OP_FORMAT  = 4'd4;

   typedef enum logic [1:0] {S_IDLE, S_TRIG, S_EMIT, S_FIN} state_t;
   state_t r_state, w_next;

   logic                  r_live;
   logic [62:0]           r_data;
   logic [3:0]            r_cam;
   logic                  r_window;
   logic                  r_err;
   logic [4:0]            r_cnt;
   logic [1:0]            r_phase;
   logic [STALL_W-1:0]    r_stall;
   logic [2*NUM_CAMS-1:0] r_comp;
   logic [NUM_CAMS-1:0]   r_rgb;
   logic [15:0]           r_trigIdx;
   logic [9:0]            r_ts;
   logic [CAM_W-1:0]      r_trigCam;

   logic [3:0] w_reqCam;
   logic [3:0] w_reqOp;
   logic       w_accept;
   logic       w_bad;
   logic       w_hs;
   logic       w_stall;
   logic       w_finalHs;
   logic       w_timeout;
   logic [4:0] w_lastIdx;
   logic [7:0] w_byte;
   logic       w_unused;

   assign w_reqCam  = cmd_addr[7:4];
   assign w_reqOp   = cmd_addr[3:0];
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_bad     = ({1'b0, w_reqCam} >= NUM_CAMS_L) ||
                      (w_reqOp == 4'd0) || (w_reqOp > OP_FORMAT);
   assign w_hs      = (r_state == S_EMIT) & i2c_ready;
   assign w_stall   = (r_state == S_EMIT) & ~i2c_ready;
   assign w_lastIdx = r_window ? 5'd11 : 5'd20;
   assign w_finalHs = w_hs & (r_cnt == w_lastIdx);
   assign w_timeout = TO_EN & w_stall & (r_stall == STALL_LIM);
   assign w_unused  = cmd_data[63];

   always_ff @(posedge sysClk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_bad)                        w_next = S_FIN;
               else if (w_reqOp == OP_TRIGGER)   w_next = S_TRIG;
               else if (w_reqOp == OP_FORMAT)    w_next = S_FIN;
               else                              w_next = S_EMIT;
            end
         end
         S_TRIG:  w_next = S_FIN;
         S_EMIT:  if (w_finalHs || w_timeout) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // r_live holds cmd_ready low while reset is asserted and for the first edge after release
   always_comb begin
      cmd_ready = 1'b0;
      i2c_valid = 1'b0;
      trigger   = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      case (r_state)
         S_IDLE:  cmd_ready = r_live;
         S_TRIG:  trigger   = 1'b1;
         S_EMIT:  i2c_valid = 1'b1;
         S_FIN: begin
            done  = ~r_err;
            error = r_err;
         end
         default: cmd_ready = 1'b0;
      endcase
   end

   always_ff @(posedge sysClk or negedge rst_n) begin
      if (!rst_n) begin
         r_live   <= 1'b0;
         r_data   <= '0;
         r_cam    <= '0;
         r_window <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
         r_phase  <= '0;
         r_stall  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_data   <= cmd_data[62:0];
            r_cam    <= w_reqCam;
            r_window <= (w_reqOp == OP_WINDOW);
            r_err    <= w_bad;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_stall  <= '0;
         end else if (r_state == S_EMIT) begin
            if (w_hs) begin
               r_cnt   <= r_cnt + 5'd1;
               r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
               r_stall <= '0;
            end else begin
               r_stall <= r_stall + 1'b1;
            end
            if (w_timeout) r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge sysClk or negedge rst_n) begin
      if (!rst_n) begin
         r_comp    <= '0;
         r_rgb     <= '0;
         r_trigIdx <= '0;
         r_ts      <= '0;
         r_trigCam <= '0;
      end else if (w_accept && !w_bad) begin
         if (w_reqOp == OP_TIMING || w_reqOp == OP_FORMAT) begin
            for (int k = 0; k < NUM_CAMS; k++) begin
               if (w_reqCam == 4'(k)) begin
                  r_rgb[k]        <= cmd_data[2];
                  r_comp[2*k +: 2] <= cmd_data[1:0];
               end
            end
         end
         if (w_reqOp == OP_TRIGGER) begin
            r_trigIdx <= cmd_data[16:1];
            r_ts      <= cmd_data[26:17];
            r_trigCam <= CAM_W'(w_reqCam);
         end
      end
   end

   // Byte tables: each group of three is register address, data high, data low
   always_comb begin
      w_byte = 8'h00;
      if (r_window) begin
         case (r_cnt)
            5'd0:    w_byte = 8'h01;
            5'd1:    w_byte = {5'b0, r_data[10:8]};
            5'd2:    w_byte = r_data[7:0];
            5'd3:    w_byte = 8'h02;
            5'd4:    w_byte = {4'b0, r_data[22:19]};
            5'd5:    w_byte = r_data[18:11];
            5'd6:    w_byte = 8'h03;
            5'd7:    w_byte = {5'b0, r_data[33:31]};
            5'd8:    w_byte = r_data[30:23];
            5'd9:    w_byte = 8'h04;
            5'd10:   w_byte = {4'b0, r_data[45:42]};
            5'd11:   w_byte = r_data[41:34];
            default: w_byte = 8'h00;
         endcase
      end else begin
         case (r_cnt)
            5'd0:    w_byte = 8'h08;
            5'd1:    w_byte = 8'h00;
            5'd2:    w_byte = {4'h0, r_data[22:19]};
            5'd3:    w_byte = 8'h09;
            5'd4:    w_byte = r_data[18:11];
            5'd5:    w_byte = r_data[10:3];
            5'd6:    w_byte = 8'h0C;
            5'd7:    w_byte = {3'b0, r_data[35:31]};
            5'd8:    w_byte = r_data[30:23];
            5'd9:    w_byte = 8'h22;
            5'd10:   w_byte = 8'h00;
            5'd11:   w_byte = {2'b0, r_data[37:36], 4'h0};
            5'd12:   w_byte = 8'h23;
            5'd13:   w_byte = 8'h00;
            5'd14:   w_byte = {2'b0, r_data[39:38], 4'h0};
            5'd15:   w_byte = 8'h05;
            5'd16:   w_byte = {4'h0, r_data[51:48]};
            5'd17:   w_byte = r_data[47:40];
            5'd18:   w_byte = 8'h06;
            5'd19:   w_byte = {5'b0, r_data[62:60]};
            5'd20:   w_byte = r_data[59:52];
            default: w_byte = 8'h00;
         endcase
      end
   end

   assign i2c_byte       = i2c_valid ? w_byte : 8'h00;
   assign i2c_frame_last = i2c_valid & (r_phase == 2'd2);
   assign i2c_cam        = CAM_W'(r_cam);
   assign compression    = r_comp;
   assign rgb            = r_rgb;
   assign trigger_index  = r_trigIdx;
   assign timestamp      = r_ts;
   assign trigger_cam    = r_trigCam;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: table of directed instructions, reset sequences and random
// instructions, all checked against a register-write level model of the sequencer.
module tb_cam_cfg_sequencer;

   localparam int NUM_CAMS = 2;
   localparam int CAM_W    = 1;
   localparam int TIMEOUT  = 8;

   logic                  sysClk = 1'b0;
   logic                  rst_n;
   logic [7:0]            cmd_addr;
   logic [63:0]           cmd_data;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [7:0]            i2c_byte;
   logic                  i2c_valid;
   logic                  i2c_ready;
   logic                  i2c_frame_last;
   logic [CAM_W-1:0]      i2c_cam;
   logic [2*NUM_CAMS-1:0] compression;
   logic [NUM_CAMS-1:0]   rgb;
   logic                  trigger;
   logic [CAM_W-1:0]      trigger_cam;
   logic [15:0]           trigger_index;
   logic [9:0]            timestamp;
   logic                  done;
   logic                  error;

   always #5 sysClk = ~sysClk;

   cam_cfg_sequencer #(.NUM_CAMS(NUM_CAMS), .CAM_W(CAM_W), .TIMEOUT(TIMEOUT)) dut (
      .sysClk(sysClk), .rst_n(rst_n),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .i2c_byte(i2c_byte), .i2c_valid(i2c_valid), .i2c_ready(i2c_ready),
      .i2c_frame_last(i2c_frame_last), .i2c_cam(i2c_cam),
      .compression(compression), .rgb(rgb),
      .trigger(trigger), .trigger_cam(trigger_cam), .trigger_index(trigger_index),
      .timestamp(timestamp), .done(done), .error(error)
   );

   // mode: 0 ready held high, 1 ready pattern 1-0-0-1, 2 ready held low, 3 random ready
   typedef struct {
      logic [7:0]  addr;
      logic [63:0] data;
      int          mode;
      bit          expDone;
      bit          expErr;
      int          expBytes;
      int          expDoneCyc;
   } vec_t;

   vec_t vecs[10];

   int total = 0;
   int bad   = 0;

   logic [NUM_CAMS-1:0]   mRgb;
   logic [2*NUM_CAMS-1:0] mComp;
   logic [15:0]           mTrigIdx;
   logic [9:0]            mTs;
   logic [CAM_W-1:0]      mTrigCam;
   logic [7:0]            expQ[$];
   logic [7:0]            gotQ[$];
   bit                    lastQ[$];

   int rDone, rErr, rTrig, rValid, rDoneCyc;

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic logic [63:0] outVec();
      return 64'({cmd_ready, i2c_byte, i2c_valid, i2c_frame_last, i2c_cam, compression, rgb,
                  trigger, trigger_cam, trigger_index, timestamp, done, error});
   endfunction

   task automatic modelReset();
      mRgb = '0; mComp = '0; mTrigIdx = '0; mTs = '0; mTrigCam = '0;
   endtask

   task automatic addWrite(input logic [7:0] regAddr, input logic [15:0] value);
      expQ.push_back(regAddr);
      expQ.push_back(value[15:8]);
      expQ.push_back(value[7:0]);
   endtask

   task automatic modelCmd(input logic [7:0] a, input logic [63:0] d, output bit isBad);
      int cam, op;
      cam = int'(a[7:4]);
      op  = int'(a[3:0]);
      expQ.delete();
      isBad = (cam >= NUM_CAMS) || (op < 1) || (op > 4);
      if (isBad) return;
      if (op == 2 || op == 4) begin
         mRgb[cam]         = d[2];
         mComp[2*cam +: 2] = d[1:0];
      end
      if (op == 1) begin
         mTrigIdx = d[16:1];
         mTs      = d[26:17];
         mTrigCam = CAM_W'(cam);
      end
      if (op == 2) begin
         addWrite(8'h08, 16'(d[22:19]));
         addWrite(8'h09, d[18:3]);
         addWrite(8'h0C, 16'(d[35:23]));
         addWrite(8'h22, 16'({d[37:36], 4'h0}));
         addWrite(8'h23, 16'({d[39:38], 4'h0}));
         addWrite(8'h05, 16'(d[51:40]));
         addWrite(8'h06, 16'(d[62:52]));
      end
      if (op == 3) begin
         addWrite(8'h01, 16'(d[10:0]));
         addWrite(8'h02, 16'(d[22:11]));
         addWrite(8'h03, 16'(d[33:23]));
         addWrite(8'h04, 16'(d[45:34]));
      end
   endtask

   task automatic applyStimulus(input logic [7:0] addr, input logic [63:0] data, input int mode,
                                input logic [CAM_W-1:0] expCam);
      int waitCnt, cyc, stallRun;
      bit fin, prevStall;
      logic [7:0] prevByte;
      gotQ.delete(); lastQ.delete();
      rDone = 0; rErr = 0; rTrig = 0; rValid = 0; rDoneCyc = -1;
      cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
      waitCnt = 0;
      while (cmd_ready !== 1'b1 && waitCnt < 20) begin
         @(posedge sysClk); #1;
         waitCnt++;
      end
      if (cmd_ready !== 1'b1) begin
         checkOutput("acceptWait", 64'(cmd_ready), 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge sysClk); #1;
      cmd_valid = 1'b0;
      cmd_data  = {$urandom, $urandom};
      cmd_addr  = 8'($urandom);
      cyc = 0; fin = 1'b0; prevStall = 1'b0; prevByte = '0; stallRun = 0;
      while (!fin && cyc < 300) begin
         case (mode)
            0:       i2c_ready = 1'b1;
            1:       i2c_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       i2c_ready = 1'b0;
            default: i2c_ready = (stallRun >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
         endcase
         stallRun = i2c_ready ? 0 : stallRun + 1;
         if (trigger) rTrig++;
         if (done)  begin rDone++; rDoneCyc = cyc; fin = 1'b1; end
         if (error) begin rErr++;  rDoneCyc = cyc; fin = 1'b1; end
         if (i2c_valid) begin
            rValid++;
            checkOutput("i2cCam", 64'(i2c_cam), 64'(expCam));
            if (prevStall) checkOutput("byteHeld", 64'(i2c_byte), 64'(prevByte));
            if (i2c_ready) begin
               gotQ.push_back(i2c_byte);
               lastQ.push_back(i2c_frame_last);
            end
         end
         prevStall = i2c_valid & ~i2c_ready;
         prevByte  = i2c_byte;
         @(posedge sysClk); #1;
         cyc++;
      end
      i2c_ready = 1'b0;
      if (!fin) checkOutput("finishBound", 64'd0, 64'd1);
      checkOutput("idleAfterFin", 64'({cmd_ready, done, error, trigger, i2c_valid}), 64'b10000);
   endtask

   task automatic runVec(input vec_t v);
      bit isBad;
      modelCmd(v.addr, v.data, isBad);
      applyStimulus(v.addr, v.data, v.mode, CAM_W'(v.addr[7:4]));
      checkOutput("doneCount", 64'(rDone), 64'(v.expDone));
      checkOutput("errCount", 64'(rErr), 64'(v.expErr));
      checkOutput("byteCount", 64'(gotQ.size()), 64'(v.expBytes));
      for (int i = 0; i < v.expBytes && i < gotQ.size() && i < expQ.size(); i++) begin
         checkOutput($sformatf("byte%0d", i), 64'(gotQ[i]), 64'(expQ[i]));
         checkOutput($sformatf("frameLast%0d", i), 64'(lastQ[i]), 64'(i % 3 == 2));
      end
      if (v.expDoneCyc >= 0) checkOutput("doneCycle", 64'(rDoneCyc), 64'(v.expDoneCyc));
      checkOutput("trigCount", 64'(rTrig), (!isBad && v.addr[3:0] == 4'd1) ? 64'd1 : 64'd0);
      if (v.expBytes == 0 && v.mode != 2) checkOutput("noValid", 64'(rValid), 64'd0);
      if (v.mode == 2) checkOutput("stallValid", 64'(rValid), 64'(TIMEOUT));
      checkOutput("compression", 64'(compression), 64'(mComp));
      checkOutput("rgb", 64'(rgb), 64'(mRgb));
      checkOutput("triggerIndex", 64'(trigger_index), 64'(mTrigIdx));
      checkOutput("timestamp", 64'(timestamp), 64'(mTs));
      checkOutput("triggerCam", 64'(trigger_cam), 64'(mTrigCam));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got=running want=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit   tmpBad;
      vec_t w;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; i2c_ready = 1'b0;
      modelReset();
      #3;
      checkOutput("resetOutputs", outVec(), 64'd0);
      #9;
      rst_n = 1'b1;
      @(posedge sysClk); #1;
      checkOutput("readyAfterReset", 64'(cmd_ready), 64'd1);

      vecs[0] = '{8'h12, 64'h7E5D3C2B1A55E6F6, 0, 1'b1, 1'b0, 21, 21};
      vecs[1] = '{8'h03, 64'h00003FEDCBA98765, 1, 1'b1, 1'b0, 12, 24};
      vecs[2] = '{8'h01, 64'h0000000007FE2468, 0, 1'b1, 1'b0, 0, 1};
      vecs[3] = '{8'h04, 64'h0000000000000005, 0, 1'b1, 1'b0, 0, 0};
      vecs[4] = '{8'h27, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, 1'b1, 0, 0};
      vecs[5] = '{8'h22, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, 1'b1, 0, 0};
      vecs[6] = '{8'h02, 64'h0123456789ABCDEF, 2, 1'b0, 1'b1, 0, TIMEOUT};
      vecs[7] = '{8'h10, 64'h00000000000000FF, 0, 1'b0, 1'b1, 0, 0};
      vecs[8] = '{8'h02, 64'hFEDCBA9876543210, 3, 1'b1, 1'b0, 21, -1};
      vecs[9] = '{8'h13, 64'h0F0FA5A55A5AC3C3, 3, 1'b1, 1'b0, 12, -1};
      for (int i = 0; i < 10; i++) runVec(vecs[i]);

      // Reset while byte 6 of a TIMING stream is on the bus
      modelCmd(8'h12, 64'h7E5D3C2B1A55E6F6, tmpBad);
      cmd_addr = 8'h12; cmd_data = 64'h7E5D3C2B1A55E6F6; cmd_valid = 1'b1;
      @(posedge sysClk); #1;
      cmd_valid = 1'b0; i2c_ready = 1'b1;
      repeat (6) @(posedge sysClk);
      #1;
      checkOutput("preResetValid", 64'(i2c_valid), 64'd1);
      checkOutput("preResetByte", 64'(i2c_byte), 64'(expQ[6]));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncResetOutputs", outVec(), 64'd0);
      modelReset();
      i2c_ready = 1'b0;
      @(negedge sysClk);
      rst_n = 1'b1;
      w = '{8'h03, 64'h0000155533336789, 0, 1'b1, 1'b0, 12, 12};
      runVec(w);

      for (int n = 0; n < 25; n++) begin
         vec_t r;
         logic [3:0] cam, op;
         bit b;
         cam = 4'($urandom_range(0, 2));
         op  = 4'($urandom_range(0, 5));
         b   = (int'(cam) >= NUM_CAMS) || (op == 4'd0) || (op > 4'd4);
         r.addr = {cam, op};
         r.data = {$urandom, $urandom};
         r.mode = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 3);
         r.expDone  = !b;
         r.expErr   = b;
         r.expBytes = b ? 0 : ((op == 4'd2) ? 21 : ((op == 4'd3) ? 12 : 0));
         r.expDoneCyc = (r.mode != 0) ? -1 : (b ? 0 : ((op == 4'd1) ? 1 : r.expBytes));
         runVec(r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
